// File: rtl/exec_ctrl.sv
// Execute-stage controller with an 8-entry register file that drives a registered ALU.
// Optional feature: define EXEC_CTRL_OVERLAP_EN to accept the next instruction during writeback.
module exec_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_REGS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [2:0]           instr_op,
    input  logic [2:0]           instr_rd,
    input  logic [2:0]           instr_rs1,
    input  logic [2:0]           instr_rs2,
    input  logic                 instr_imm_sel,
    input  logic [WORD_SIZE-1:0] instr_imm,
    output logic [2:0]           alu_op,
    output logic [WORD_SIZE-1:0] alu_in1,
    output logic [WORD_SIZE-1:0] alu_in2,
    output logic                 alu_enable,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic                 done,
    output logic [2:0]           done_rd,
    output logic [WORD_SIZE-1:0] done_data,
    input  logic [2:0]           dbg_addr,
    output logic [WORD_SIZE-1:0] dbg_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic                 ready_q, ready_d;
    logic [2:0]           op_q, op_d;
    logic [2:0]           rd_q, rd_d;
    logic [2:0]           rs1_q, rs1_d;
    logic [2:0]           rs2_q, rs2_d;
    logic                 imm_sel_q, imm_sel_d;
    logic [WORD_SIZE-1:0] imm_q, imm_d;
    logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
    logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
    logic                 accept;
    logic                 ready_state;

    // ready_q keeps instr_ready low while reset is asserted, even though the FSM sits in IDLE.
    always_comb begin
        ready_state = (state_q == S_IDLE);
`ifdef EXEC_CTRL_OVERLAP_EN
        if (state_q == S_WB) begin
            ready_state = 1'b1;
        end
`endif
    end

    assign instr_ready = ready_q && ready_state;
    assign accept      = instr_valid && instr_ready;

    always_comb begin
        ready_d   = 1'b1;
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = accept ? S_EXEC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            op_d      = instr_op;
            rd_d      = instr_rd;
            rs1_d     = instr_rs1;
            rs2_d     = instr_rs2;
            imm_sel_d = instr_imm_sel;
            imm_d     = instr_imm;
        end
    end

    // Register 0 is never written so it stays at its reset value of zero.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if ((state_q == S_WB) && (rd_q == 3'(i)) && (i != 0)) begin
                regs_d[i] = alu_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ready_q   <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        alu_enable = 1'b0;
        alu_op     = '0;
        alu_in1    = '0;
        alu_in2    = '0;
        if (state_q == S_EXEC) begin
            alu_enable = 1'b1;
            alu_op     = op_q;
            alu_in1    = regs_q[rs1_q];
            alu_in2    = imm_sel_q ? imm_q : regs_q[rs2_q];
        end
    end

    assign done      = (state_q == S_WB);
    assign done_rd   = done ? rd_q : 3'd0;
    assign done_data = done ? alu_out : '0;
    assign dbg_data  = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execute-stage controller and register file that feeds the ALU. It accepts one decoded instruction per handshake and reads two source registers (or one register and an immediate). It drives the ALU's op/operand/enable inputs for one cycle, captures the ALU's registered result on the following cycle, and writes it back to the destination register. It sits between instruction decode (upstream) and the ALU (downstream of its operand ports, upstream of its writeback).

## Interface
- WORD_SIZE, from parameters.vh (16): datapath width; shared with the ALU.
- NUM_REGS, 8: register count; fixed at 8 (3-bit indices).

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset; one clock domain.
- instr_valid  in  1  decode presents an instruction.
- instr_ready  out  1  controller can accept an instruction this cycle.
- instr_op  in  3  ALU op code (`ALU_ADD` … `ALU_SHIFT`).
- instr_rd, instr_rs1, instr_rs2  in  3 each  destination and source register indices.
- instr_imm_sel  in  1  1: second operand = instr_imm instead of rs2.
- instr_imm  in  WORD_SIZE  immediate operand.
- alu_op  out  3  to ALU op.
- alu_in1, alu_in2  out  WORD_SIZE  to ALU operands.
- alu_enable  out  1  to ALU enable.
- alu_out  in  WORD_SIZE  registered ALU result.
- done  out  1  one-cycle pulse: writeback occurring this cycle.
- done_rd  out  3  destination of the completing instruction.
- done_data  out  WORD_SIZE  value being written.
- dbg_addr  in  3  debug read index.
- dbg_data  out  WORD_SIZE  combinational read of regs[dbg_addr]; 0 when dbg_addr=0.

## Operation
- FSM states: IDLE, EXEC, WB. Reset state is IDLE.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch op/rd/rs1/rs2/imm_sel/imm and go to EXEC. The latched fields are stable for the rest of the instruction. Input changes after acceptance are ignored.
- EXEC: alu_enable=1. alu_op = latched op. alu_in1 = regs[rs1]. alu_in2 = imm_sel ? imm : regs[rs2]. Operands are read from the register file in this cycle. Go to WB.
- WB: alu_out holds the result. regs[rd] <= alu_out at the end of the cycle. done=1, done_rd=rd, done_data=alu_out (combinational from alu_out). Go to IDLE.
- Register 0 always reads 0. Writes to rd=0 are discarded, but done still pulses with the ALU value on done_data.
- Outside EXEC: alu_enable=0, and alu_op/alu_in1/alu_in2 are driven to 0.
- Arithmetic and width behaviour belongs to the ALU. The controller passes full WORD_SIZE values unmodified; no sign extension of the immediate.
- Reset values: instr_ready=0 while rst_n low, then 1 in IDLE. alu_enable=0, alu_*=0, done=0, done_rd=0, done_data=0, all registers 0.
- Reset mid-operation (in EXEC or WB): state returns to IDLE immediately, no register write occurs, and done never pulses.

## Timing
- Acceptance at edge T0. EXEC is cycle T0→T1; the ALU registers its result at T1. WB is cycle T1→T2; the register write and done pulse land at T2.
- Latency from acceptance to register write is 2 cycles.
- Throughput is 1 instruction per 3 cycles (base build).
- A dependent instruction accepted after WB reads the updated value; no forwarding is needed.

## Configuration
- EXEC_CTRL_OVERLAP_EN defined:
  - instr_ready is also 1 in WB.
  - An instruction accepted in WB goes directly to EXEC.
  - Throughput is 1 per 2 cycles.
  - The new EXEC reads registers after the WB write has landed, so RAW on the prior rd sees the new value.
- EXEC_CTRL_OVERLAP_EN undefined: instr_ready=0 in WB, and the FSM always passes through IDLE.

## Test plan
- Reset, then drive dbg_addr through 0–7 → every dbg_data=0; instr_ready=1 one cycle after rst_n rises; done=0.
- r1 setup: ADD r1=r0+imm 5 (imm_sel=1).
  - During EXEC: alu_in1=0, alu_in2=5, alu_enable=1.
  - 2 cycles after acceptance: done=1, done_rd=1, done_data=5, and dbg r1=5.
- RAW: with r1=5, r2=3, issue SUB r3=r1-r2 immediately followed by ADD r4=r3+r3.
  - Result: r3=2, r4=4.
  - Acceptance spacing is 3 cycles (base) or 2 cycles (overlap).
- Write to r0: ADD r0=r0+imm 9 → done_data=9, but dbg r0 stays 0.
- Reset mid-op: assert rst_n low during EXEC of ADD r5=r0+imm 7 → no done pulse, and r5=0 after reset release.
- Handshake hold: instr_valid held with changing fields while instr_ready=0 → only fields present at the accepting edge take effect; alu_enable is high for exactly 1 cycle per instruction.
